seq1001_scan_ctrl: RTL and testbench

- Sequencing controller for the team's serial "1001" Mealy sequence detector (input x, combinational output z, overlapping detection).
- Accepts a parallel word over a valid/ready handshake and clears the detector. It then shifts the word into the detector MSB-first, one bit per clock, and counts z pulses.
- Reports hit count, first-hit position and a done pulse.
- Sits between a host/register interface and one detector instance.

---
 rtl/seq1001_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seq1001_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq1001_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq1001_scan_ctrl
//  Description : Sequencing controller for a serial "1001" Mealy detector.
//                Accepts a parallel word over valid/ready, clears the
//                detector, shifts the word MSB-first and counts z pulses.
//                Reports hit count, first-hit index and a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq1001_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    output logic             det_x,
    output logic             det_rst,
    input  logic             det_z,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] hit_count,
    output logic             hit_found,
    output logic [IDX_W-1:0] first_hit_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] w_bit_idx_next;

    // Working results for the scan in progress
    logic [CNT_W-1:0] r_work_cnt;
    logic [CNT_W-1:0] w_work_cnt_next;
    logic             r_work_hit;
    logic             w_work_hit_next;
    logic [IDX_W-1:0] r_work_first;
    logic [IDX_W-1:0] w_work_first_next;

    // Published results of the last completed scan
    logic [CNT_W-1:0] r_hit_count;
    logic             r_hit_found;
    logic [IDX_W-1:0] r_first_hit_idx;

    logic             r_det_x;
    logic             r_det_rst;
    logic             r_aborted;
    logic             w_abort_take;
    logic             w_publish;

    // Next-state, datapath next values and abort qualification
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_idx_next    = r_bit_idx;
        w_work_cnt_next   = r_work_cnt;
        w_work_hit_next   = r_work_hit;
        w_work_first_next = r_work_first;
        w_abort_take      = 1'b0;
        w_publish         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_valid) begin
                    w_shift_next      = data_in;
                    w_bit_idx_next    = '0;
                    w_work_cnt_next   = '0;
                    w_work_hit_next   = 1'b0;
                    w_work_first_next = '0;
                    w_state_next      = ST_CLR;
                end
            end
            ST_CLR: begin
                if (abort) begin
                    w_abort_take = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_abort_take = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    if (det_z) begin
                        if (r_work_cnt != c_CNT_MAX) begin
                            w_work_cnt_next = r_work_cnt + 1'b1;
                        end
                        if (!r_work_hit) begin
                            w_work_hit_next   = 1'b1;
                            w_work_first_next = r_bit_idx;
                        end
                    end
                    w_shift_next   = {r_shift[WIDTH-2:0], 1'b0};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == c_LAST_IDX) begin
                        w_state_next = ST_DONE;
                        w_publish    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and result registers; det_x/det_rst are registered so
    // the detector sees clean levels
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_shift         <= '0;
            r_bit_idx       <= '0;
            r_work_cnt      <= '0;
            r_work_hit      <= 1'b0;
            r_work_first    <= '0;
            r_hit_count     <= '0;
            r_hit_found     <= 1'b0;
            r_first_hit_idx <= '0;
            r_det_x         <= 1'b0;
            r_det_rst       <= 1'b0;
            r_aborted       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_work_cnt   <= w_work_cnt_next;
            r_work_hit   <= w_work_hit_next;
            r_work_first <= w_work_first_next;
            r_det_x      <= (w_state_next == ST_SHIFT) & w_shift_next[WIDTH-1];
            r_det_rst    <= (w_state_next == ST_CLR) | w_abort_take;
            r_aborted    <= w_abort_take;
            if (w_publish) begin
                r_hit_count     <= w_work_cnt_next;
                r_hit_found     <= w_work_hit_next;
                r_first_hit_idx <= w_work_first_next;
            end
        end
    end

    assign start_ready   = (r_state == ST_IDLE);
    assign busy          = (r_state == ST_CLR) || (r_state == ST_SHIFT);
    assign done          = (r_state == ST_DONE);
    assign aborted       = r_aborted;
    assign det_x         = r_det_x;
    // The reset term keeps the detector cleared for as long as reset is held
    assign det_rst       = reset | r_det_rst;
    assign hit_count     = r_hit_count;
    assign hit_found     = r_hit_found;
    assign first_hit_idx = r_first_hit_idx;

endmodule
`default_nettype wire

// File: tb/tb_seq1001_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq1001_scan_ctrl
//  Description : Directed self-checking bench for seq1001_scan_ctrl with a
//                behavioural "1001" Mealy detector attached to each instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq1001_scan_ctrl;

    logic       clock;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] data_in;
    logic       abort;
    logic       det_x;
    logic       det_rst;
    logic       det_z;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] hit_count;
    logic       hit_found;
    logic [2:0] first_hit_idx;

    // Second instance with a one-bit saturating counter
    logic       s_start_valid;
    logic       s_start_ready;
    logic [7:0] s_data_in;
    logic       s_det_x;
    logic       s_det_rst;
    logic       s_det_z;
    logic       s_busy;
    logic       s_done;
    logic       s_aborted;
    logic [0:0] s_hit_count;
    logic       s_hit_found;
    logic [2:0] s_first_hit_idx;

    int n_checks = 0;
    int n_errors = 0;

    seq1001_scan_ctrl #(.WIDTH(8), .CNT_W(4), .IDX_W(3)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .data_in       (data_in),
        .abort         (abort),
        .det_x         (det_x),
        .det_rst       (det_rst),
        .det_z         (det_z),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .hit_count     (hit_count),
        .hit_found     (hit_found),
        .first_hit_idx (first_hit_idx)
    );

    seq1001_scan_ctrl #(.WIDTH(8), .CNT_W(1), .IDX_W(3)) u_sat (
        .clock         (clock),
        .reset         (reset),
        .start_valid   (s_start_valid),
        .start_ready   (s_start_ready),
        .data_in       (s_data_in),
        .abort         (1'b0),
        .det_x         (s_det_x),
        .det_rst       (s_det_rst),
        .det_z         (s_det_z),
        .busy          (s_busy),
        .done          (s_done),
        .aborted       (s_aborted),
        .hit_count     (s_hit_count),
        .hit_found     (s_hit_found),
        .first_hit_idx (s_first_hit_idx)
    );

    // Detector models: 0 = idle, 1 = "1", 2 = "10", 3 = "100"
    logic [1:0] dst;
    logic [1:0] s_dst;

    function automatic logic [1:0] det_next(input logic [1:0] st, input logic x);
        case (st)
            2'd0:    det_next = x ? 2'd1 : 2'd0;
            2'd1:    det_next = x ? 2'd1 : 2'd2;
            2'd2:    det_next = x ? 2'd1 : 2'd3;
            default: det_next = x ? 2'd1 : 2'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (det_rst) dst <= 2'd0;
        else         dst <= det_next(dst, det_x);
    end

    always @(posedge clock) begin
        if (s_det_rst) s_dst <= 2'd0;
        else           s_dst <= det_next(s_dst, s_det_x);
    end

    assign det_z   = (dst == 2'd3) && det_x;
    assign s_det_z = (s_dst == 2'd3) && s_det_x;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full scan: accept, CLR, eight SHIFT cycles with det_x checked, DONE, IDLE
    task automatic run_scan(input string tag, input logic [7:0] d,
                            input int exp_cnt, input int exp_found, input int exp_idx);
        start_valid = 1'b1;
        data_in     = d;
        tick();
        start_valid = 1'b0;
        data_in     = 8'h00;
        check({tag, "_clr_busy"},  busy, 1);
        check({tag, "_clr_ready"}, start_ready, 0);
        check({tag, "_clr_rst"},   det_rst, 1);
        check({tag, "_clr_x"},     det_x, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("%s_x%0d", tag, i),    det_x, d[7-i]);
            check($sformatf("%s_rst%0d", tag, i),  det_rst, 0);
            check($sformatf("%s_done%0d", tag, i), done, 0);
        end
        tick();
        check({tag, "_done"},  done, 1);
        check({tag, "_ready"}, start_ready, 0);
        check({tag, "_cnt"},   hit_count, exp_cnt);
        check({tag, "_found"}, hit_found, exp_found);
        check({tag, "_idx"},   first_hit_idx, exp_idx);
        check({tag, "_drst"},  det_rst, 0);
        tick();
        check({tag, "_idle_done"},  done, 0);
        check({tag, "_idle_ready"}, start_ready, 1);
        check({tag, "_hold_cnt"},   hit_count, exp_cnt);
    endtask

    initial begin
        logic [7:0] pat;
        int         m;
        reset         = 1'b1;
        start_valid   = 1'b0;
        data_in       = 8'h00;
        abort         = 1'b0;
        s_start_valid = 1'b0;
        s_data_in     = 8'h00;
        tick();
        tick();
        check("rst_ready",   start_ready, 1);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_cnt",     hit_count, 0);
        check("rst_found",   hit_found, 0);
        check("rst_idx",     first_hit_idx, 0);
        check("rst_detrst",  det_rst, 1);
        check("rst_x",       det_x, 0);
        reset = 1'b0;
        tick();
        check("post_rst_detrst", det_rst, 0);

        // Basic scans
        run_scan("s1", 8'b1001_0010, 2, 1, 3);
        run_scan("s2", 8'b0000_0000, 0, 0, 0);
        run_scan("s3", 8'b1001_1001, 2, 1, 3);
        // 0,1,1,0,0,1,0,0 holds "1001" at bits 2..5 -> one hit at index 5
        run_scan("s4", 8'b0110_0100, 1, 1, 5);

        // Abort during the fourth SHIFT cycle
        start_valid = 1'b1;
        data_in     = 8'b1001_0010;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_pulse",  aborted, 1);
        check("ab_detrst", det_rst, 1);
        check("ab_done",   done, 0);
        check("ab_busy",   busy, 0);
        check("ab_ready",  start_ready, 1);
        check("ab_cnt",    hit_count, 1);
        check("ab_found",  hit_found, 1);
        check("ab_idx",    first_hit_idx, 5);
        tick();
        check("ab_pulse_end", aborted, 0);
        check("ab_rst_end",   det_rst, 0);
        // Abort while idle has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle_ign", aborted, 0);
        check("ab_idle_rdy", start_ready, 1);
        run_scan("s5", 8'b0100_1000, 1, 1, 4);

        // Reset in the middle of SHIFT
        start_valid = 1'b1;
        data_in     = 8'b1001_1001;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mr_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_ready",   start_ready, 1);
        check("mr_busy",    busy, 0);
        check("mr_cnt",     hit_count, 0);
        check("mr_found",   hit_found, 0);
        check("mr_idx",     first_hit_idx, 0);
        check("mr_done",    done, 0);
        check("mr_aborted", aborted, 0);
        tick();
        check("mr_done2",    done, 0);
        check("mr_aborted2", aborted, 0);

        // Saturation with start_valid held high: accepts every 11 cycles
        pat           = 8'b1001_0010;
        s_start_valid = 1'b1;
        s_data_in     = pat;
        tick();
        for (int k = 0; k < 22; k++) begin
            m = k % 11;
            check($sformatf("sat_ready%0d", k), s_start_ready, (m == 10) ? 1 : 0);
            check($sformatf("sat_busy%0d", k),  s_busy,        (m <= 8)  ? 1 : 0);
            check($sformatf("sat_done%0d", k),  s_done,        (m == 9)  ? 1 : 0);
            if (m >= 1 && m <= 8) begin
                check($sformatf("sat_x%0d", k), s_det_x, pat[8-m]);
            end
            if (m == 9) begin
                check($sformatf("sat_cnt%0d", k),   s_hit_count, 1);
                check($sformatf("sat_found%0d", k), s_hit_found, 1);
                check($sformatf("sat_idx%0d", k),   s_first_hit_idx, 3);
            end
            tick();
        end
        s_start_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
